// File: rtl/mdu_pkg.sv
// mdu_pkg: opcodes, op-class helpers and FSM state encoding for muldiv_unit
package mdu_pkg;
   localparam logic [3:0] MDU_NONE  = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MTHI  = 4'd5;
   localparam logic [3:0] MDU_MTLO  = 4'd6;
   localparam logic [3:0] MDU_MADD  = 4'd7;
   localparam logic [3:0] MDU_MADDU = 4'd8;
   localparam logic [3:0] MDU_MSUB  = 4'd9;
   localparam logic [3:0] MDU_MSUBU = 4'd10;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} mdu_state_e;

   // Multiply-accumulate ops only join the mult class when MDU_MACC_EN is defined
   function automatic logic is_mul(input logic [3:0] op);
`ifdef MDU_MACC_EN
      return op == MDU_MULT || op == MDU_MULTU || op == MDU_MADD || op == MDU_MADDU ||
             op == MDU_MSUB || op == MDU_MSUBU;
`else
      return op == MDU_MULT || op == MDU_MULTU;
`endif
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return op == MDU_DIV || op == MDU_DIVU;
   endfunction
endpackage

// File: rtl/md_delay_counter.sv
// md_delay_counter: loadable down-counter with zero flag that times MDU latency
module md_delay_counter #(
   parameter int CW = 4
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   input  logic          dec_i,
   output logic          zero_o
);
   logic [CW-1:0] cnt_q, cnt_d;

   // Load has priority; decrement saturates at zero
   always_comb begin
      cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
   end

   // Count register
   always_ff @(posedge clk_i) begin
      cnt_q <= reset_i ? '0 : cnt_d;
   end

   assign zero_o = cnt_q == '0;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit owning HI/LO; MDU_MACC_EN adds MADD/MADDU/MSUB/MSUBU
module muldiv_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);
   localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   mdu_state_e state_q, state_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [2*WIDTH-1:0] res_q, res_d, md_res, prod_s, prod_u;
   logic [WIDTH-1:0] quot_s, rem_s, quot_u, rem_u;
   logic done_q, done_d, load, dec, zero, acc;
   logic [CW-1:0] load_val;

   assign acc    = start_i && state_q == IDLE;
   assign prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
   assign prod_s = {{WIDTH{a_i[WIDTH-1]}}, a_i} * {{WIDTH{b_i[WIDTH-1]}}, b_i};
   assign quot_s = $signed(a_i) / $signed(b_i);
   assign rem_s  = $signed(a_i) % $signed(b_i);
   assign quot_u = a_i / b_i;
   assign rem_u  = a_i % b_i;
   assign load_val = is_mul(op_i) ? CW'(MUL_CYCLES - 1) : CW'(DIV_CYCLES - 1);

   md_delay_counter #(.CW(CW)) u_cnt (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .load_i     (load),
      .load_val_i (load_val),
      .dec_i      (dec),
      .zero_o     (zero)
   );

   // Result of the presented op as {hi,lo}, including div-by-zero and MIN/-1 cases
   always_comb begin
      md_res = {hi_q, lo_q};
      case (op_i)
         MDU_MULT:  md_res = prod_s;
         MDU_MULTU: md_res = prod_u;
         MDU_DIV:   md_res = (b_i == '0) ? {a_i, {WIDTH{1'b1}}} :
                             (a_i == SMIN && &b_i) ? {{WIDTH{1'b0}}, SMIN} : {rem_s, quot_s};
         MDU_DIVU:  md_res = (b_i == '0) ? {a_i, {WIDTH{1'b1}}} : {rem_u, quot_u};
`ifdef MDU_MACC_EN
         MDU_MADD:  md_res = {hi_q, lo_q} + prod_s;
         MDU_MADDU: md_res = {hi_q, lo_q} + prod_u;
         MDU_MSUB:  md_res = {hi_q, lo_q} - prod_s;
         MDU_MSUBU: md_res = {hi_q, lo_q} - prod_u;
`endif
         default:   md_res = {hi_q, lo_q};
      endcase
   end

   // Next state: accept md ops into RUN, retire when the counter reaches zero
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      dec     = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            load    = acc && (is_mul(op_i) || is_div(op_i));
            state_d = load ? RUN : IDLE;
         end
         RUN: begin
            done_d  = zero;
            dec     = !zero;
            state_d = zero ? IDLE : RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   // Architectural HI/LO and the shadow result captured at accept
   always_comb begin
      res_d = load ? md_res : res_q;
      hi_d  = done_d ? res_q[2*WIDTH-1:WIDTH] : (acc && op_i == MDU_MTHI) ? a_i : hi_q;
      lo_d  = done_d ? res_q[WIDTH-1:0] : (acc && op_i == MDU_MTLO) ? a_i : lo_q;
   end

   // State and data registers; reset discards any in-flight op
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         res_q   <= res_d;
      end
   end

   assign busy_o = state_q == RUN;
   assign done_o = done_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
endmodule
